// File: rtl/forwarding_unit_if.sv
// Decode/execute-side signal bundle for the forwarding unit. The pipeline
// control drives the master side; the forwarding unit sits on the slave side.
interface forwarding_unit_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [31:0] ex_alu_res;
  logic [31:0] mem_load_data;
  logic        stall_ext;
  logic        flush;
  logic        stall;
  logic        fw_data_1_valid;
  logic        fw_data_2_valid;
  logic [31:0] fw_data_1;
  logic [31:0] fw_data_2;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_res,
           mem_load_data, stall_ext, flush,
    input  stall, fw_data_1_valid, fw_data_2_valid, fw_data_1, fw_data_2
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_res,
           mem_load_data, stall_ext, flush,
    output stall, fw_data_1_valid, fw_data_2_valid, fw_data_1, fw_data_2
  );
endinterface

// File: rtl/forwarding_unit.sv
// Operand forwarding and load-use hazard detection for the 5-stage pipeline.
// Tracks EX/MEM/WB producers and registers operand overrides for the EX stage.
module forwarding_unit (
  input  logic              clk,
  input  logic              rst,
  forwarding_unit_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_load;
    logic [31:0] data;
  } slot_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } fwd_t;

  slot_t       mem_q;
  slot_t       wb_q;
  fwd_t        fw1_q;
  fwd_t        fw2_q;
  fwd_t        sel1;
  fwd_t        sel2;
  logic [31:0] mem_value;
  logic        hazard;
  logic        stall;

  // A load in MEM only has its real result on mem_load_data.
  assign mem_value = mem_q.is_load ? bus.mem_load_data : mem_q.data;

  function automatic logic produces(input logic valid, input logic reg_write,
                                    input logic [4:0] rd, input logic [4:0] rs,
                                    input logic used, input logic id_valid);
    return valid & reg_write & (rd != 5'd0) & (rd == rs) & used & id_valid;
  endfunction

  // Newest producer first: EX (non-load), then MEM, then WB.
  function automatic fwd_t select_src(input logic [4:0] rs, input logic used);
    fwd_t r;
    r = '0;
    if (produces(bus.ex_valid, bus.ex_reg_write, bus.ex_rd, rs, used, bus.id_valid)
        && !bus.ex_mem_read) begin
      r = '{valid: 1'b1, data: bus.ex_alu_res};
    end else if (produces(mem_q.valid, mem_q.reg_write, mem_q.rd, rs, used, bus.id_valid)) begin
      r = '{valid: 1'b1, data: mem_value};
    end else if (produces(wb_q.valid, wb_q.reg_write, wb_q.rd, rs, used, bus.id_valid)) begin
      r = '{valid: 1'b1, data: wb_q.data};
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    sel1   = '0;
    sel2   = '0;
    hazard = 1'b0;
    sel1   = select_src(bus.id_rs1, bus.id_rs1_used);
    sel2   = select_src(bus.id_rs2, bus.id_rs2_used);
    hazard = bus.id_valid & bus.ex_valid & bus.ex_mem_read & bus.ex_reg_write &
             (bus.ex_rd != 5'd0) &
             ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
              (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
  end

  // Gating with rst makes stall drop the instant reset asserts, not at the next edge.
  assign stall = hazard & ~bus.flush & rst;

  // NOTE: the slots are a handful of flops, not a RAM, so they are reset along
  // with the outputs and never present stale data after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wb_q  <= '0;
      fw1_q <= '0;
      fw2_q <= '0;
    end else if (!bus.stall_ext) begin
      mem_q <= '{valid:     bus.ex_valid,
                 rd:        bus.ex_rd,
                 reg_write: bus.ex_reg_write,
                 is_load:   bus.ex_mem_read,
                 data:      bus.ex_alu_res};
      wb_q  <= '{valid:     mem_q.valid,
                 rd:        mem_q.rd,
                 reg_write: mem_q.reg_write,
                 is_load:   1'b0,
                 data:      mem_value};
      if (stall || bus.flush) begin
        fw1_q <= '0;
        fw2_q <= '0;
      end else begin
        fw1_q <= sel1;
        fw2_q <= sel2;
      end
    end
  end

  assign bus.stall           = stall;
  assign bus.fw_data_1_valid = fw1_q.valid;
  assign bus.fw_data_1       = fw1_q.data;
  assign bus.fw_data_2_valid = fw2_q.valid;
  assign bus.fw_data_2       = fw2_q.data;

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: a table of per-cycle vectors with
// hand-computed results, followed by freeze and mid-stall reset sequences.
module tb_forwarding_unit;

  logic clk;
  logic rst;

  forwarding_unit_if bus ();

  forwarding_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [31:0] ex_alu_res;
    logic [31:0] mem_load_data;
    logic        flush;
    logic        exp_stall;
    logic        exp_v1;
    logic [31:0] exp_d1;
    logic        exp_v2;
    logic [31:0] exp_d2;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic stall_ext);
    bus.id_valid      = v.id_valid;
    bus.id_rs1        = v.rs1;
    bus.id_rs2        = v.rs2;
    bus.id_rs1_used   = v.rs1_used;
    bus.id_rs2_used   = v.rs2_used;
    bus.ex_valid      = v.ex_valid;
    bus.ex_rd         = v.ex_rd;
    bus.ex_reg_write  = v.ex_reg_write;
    bus.ex_mem_read   = v.ex_mem_read;
    bus.ex_alu_res    = v.ex_alu_res;
    bus.mem_load_data = v.mem_load_data;
    bus.flush         = v.flush;
    bus.stall_ext     = stall_ext;
  endtask

  task automatic check_fw(input string tag, input logic v1, input logic [31:0] d1,
                          input logic v2, input logic [31:0] d2);
    check({tag, " fw_data_1_valid"}, 32'(bus.fw_data_1_valid), 32'(v1));
    check({tag, " fw_data_1"},       bus.fw_data_1,            d1);
    check({tag, " fw_data_2_valid"}, 32'(bus.fw_data_2_valid), 32'(v2));
    check({tag, " fw_data_2"},       bus.fw_data_2,            d2);
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    //           idv rs1   rs2   u1 u2 exv ex_rd rw mr alu           mld            fl  st  v1 d1            v2 d2
    vecs[0]  = '{1, 5'd5, 5'd6, 1, 1, 1, 5'd5, 1, 0, 32'h10,       32'h0,         0,  0,  1, 32'h10,       0, 32'h0};
    vecs[1]  = '{0, 5'd3, 5'd3, 1, 1, 1, 5'd3, 1, 0, 32'h1,        32'h0,         0,  0,  0, 32'h0,        0, 32'h0};
    vecs[2]  = '{0, 5'd3, 5'd3, 1, 1, 1, 5'd3, 1, 0, 32'h2,        32'h0,         0,  0,  0, 32'h0,        0, 32'h0};
    vecs[3]  = '{1, 5'd3, 5'd5, 1, 1, 1, 5'd3, 1, 0, 32'h3,        32'h77,        0,  0,  1, 32'h3,        0, 32'h0};
    vecs[4]  = '{1, 5'd3, 5'd3, 1, 1, 1, 5'd3, 0, 0, 32'h99,       32'h0,         0,  0,  1, 32'h3,        1, 32'h3};
    vecs[5]  = '{1, 5'd3, 5'd3, 1, 0, 0, 5'd3, 1, 0, 32'h55,       32'h0,         0,  0,  1, 32'h3,        0, 32'h0};
    vecs[6]  = '{1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 0, 32'hFF,       32'h0,         0,  0,  0, 32'h0,        0, 32'h0};
    vecs[7]  = '{1, 5'd4, 5'd4, 1, 0, 1, 5'd4, 1, 0, 32'h44,       32'h0,         0,  0,  1, 32'h44,       0, 32'h0};
    vecs[8]  = '{1, 5'd1, 5'd7, 1, 1, 1, 5'd7, 1, 1, 32'h1000,     32'h0,         0,  1,  0, 32'h0,        0, 32'h0};
    vecs[9]  = '{1, 5'd1, 5'd7, 1, 1, 0, 5'd0, 0, 0, 32'h0,        32'hDEADBEEF,  0,  0,  0, 32'h0,        1, 32'hDEADBEEF};
    vecs[10] = '{1, 5'd7, 5'd4, 1, 1, 1, 5'd9, 1, 0, 32'h5,        32'h0,         0,  0,  1, 32'hDEADBEEF, 0, 32'h0};
    vecs[11] = '{1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 1, 32'h2000,     32'h0,         1,  0,  0, 32'h0,        0, 32'h0};
    vecs[12] = '{1, 5'd9, 5'd8, 1, 1, 0, 5'd0, 0, 0, 32'h0,        32'h12345678,  0,  0,  1, 32'h5,        1, 32'h12345678};

    // Reset with a load-use pattern on the inputs: stall must stay low.
    rst = 1'b0;
    drive(vecs[8], 1'b0);
    #3;
    check("reset stall", 32'(bus.stall), 32'h0);
    check_fw("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i], 1'b0);
      #2;
      check($sformatf("row%0d stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      check_fw($sformatf("row%0d", i), vecs[i].exp_v1, vecs[i].exp_d1,
               vecs[i].exp_v2, vecs[i].exp_d2);
    end

    // Freeze for three cycles with a load-use hazard present.
    v = '{1, 5'd0, 5'd7, 0, 1, 1, 5'd7, 1, 1, 32'h3000, 32'hCAFE, 0, 1, 0, 32'h0, 0, 32'h0};
    for (int c = 0; c < 3; c++) begin
      drive(v, 1'b1);
      #2;
      check($sformatf("freeze%0d stall", c), 32'(bus.stall), 32'h1);
      @(posedge clk);
      #1;
      check_fw($sformatf("freeze%0d", c), 1'b1, 32'h5, 1'b1, 32'h12345678);
    end

    // Unfrozen: the WB slot must still hold x8 from before the freeze.
    v = '{1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0, 0, 32'h0, 32'hFFFF, 0, 0, 0, 32'h0, 0, 32'h0};
    drive(v, 1'b0);
    #2;
    check("thaw stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    check_fw("thaw", 1'b1, 32'h12345678, 1'b0, 32'h0);

    // Reset asserted mid-stall, away from any clock edge.
    v = '{1, 5'd0, 5'd7, 0, 1, 1, 5'd7, 1, 1, 32'h3000, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0};
    drive(v, 1'b0);
    #2;
    check("prereset stall", 32'(bus.stall), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("midreset stall", 32'(bus.stall), 32'h0);
    check_fw("midreset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First advancing edge after reset captures EX into the MEM slot.
    v = '{0, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0};
    drive(v, 1'b0);
    @(posedge clk);
    #1;
    check_fw("postreset0", 1'b0, 32'h0, 1'b0, 32'h0);
    v = '{1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0};
    drive(v, 1'b0);
    @(posedge clk);
    #1;
    check_fw("postreset1", 1'b1, 32'h10, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Operand-forwarding and load-use hazard unit for the 5-stage pipeline. Tracks the destination register and result of every in-flight instruction in EX, MEM and WB. Compares them with the source registers of the instruction in decode. Drives the registered `fw_data_1/2` and `fw_data_1/2_valid` operand overrides consumed by the execute stage, and raises a one-cycle load-use stall when a dependency cannot be forwarded in time.

## Interface
- No parameters; XLEN fixed at 32, register index 5 bits.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a live instruction.
- `id_rs1`, `id_rs2` in 5: decode source register indices.
- `id_rs1_used`, `id_rs2_used` in 1: instruction actually reads rs1/rs2.
- `ex_valid` in 1: EX holds a live instruction.
- `ex_rd` in 5: EX destination register.
- `ex_reg_write` in 1: EX instruction writes the register file.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_alu_res` in 32: execute-stage `alu_res`.
- `mem_load_data` in 32: load data returned for the instruction in MEM.
- `stall_ext` in 1: external pipeline freeze, e.g. memory busy.
- `flush` in 1: branch taken in EX; kills the decode instruction.
- `stall` out 1: load-use hazard; hold IF/ID and insert a bubble into EX.
- `fw_data_1_valid`, `fw_data_2_valid` out 1: forward valid for the instruction now in EX.
- `fw_data_1`, `fw_data_2` out 32: forwarded operand values.

## Operation
- Internal slots MEM and WB each hold {valid, rd, reg_write, is_load, data}.
- Advancing edge: `stall_ext`=0. On that edge:
  - MEM slot loads {ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_res}.
  - WB slot loads MEM slot, with data = is_load ? `mem_load_data` : MEM.data, and is_load cleared.
- A source is a producer when valid & reg_write & rd≠0 & rd==rs & rs_used & `id_valid`.
- Forward selection per operand, newest first:
  - EX: value `ex_alu_res`. Not eligible if `ex_mem_read`=1.
  - MEM slot: value = is_load ? `mem_load_data` : data.
  - WB slot: value data.
  - No match: valid=0, data=0.
- x0 is never forwarded; rs=0 always gives valid=0.
- hazard = `id_valid` & `ex_valid` & `ex_mem_read` & `ex_reg_write` & `ex_rd`≠0 & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
- `stall` = hazard & ~`flush` & `rst`. It is combinational.
- Output registers, updated on the clock edge:
  - `stall_ext`=1: hold all outputs and slots.
  - Advancing, `stall`=0, `flush`=0: load the forward selection for decode's operands (decode moves to EX).
  - Advancing with `stall`=1 or `flush`=1: clear both valids and data (bubble enters EX).
- Simultaneous flush and hazard: flush wins. No stall, bubble.
- Simultaneous `stall_ext` and hazard: `stall` stays asserted; nothing updates.
- Register file writes at the end of WB, so the WB slot must be forwarded. Reads are not write-through.

## Timing
- Reset (`rst`=0, async): slots invalid with data 0; all `fw_*` outputs 0; `stall`=0. Reset mid-stall drops `stall` immediately.
- First advancing edge after reset release: slots capture the EX inputs normally.
- Forward latency: 1 cycle. Selection is made in the decode cycle and presented for the whole EX cycle of the consumer.
- Load-use: exactly one stall cycle per dependent load, absent `stall_ext`. On the next cycle the load sits in the MEM slot and is forwarded from `mem_load_data`.
- Back-to-back producers to the same rd: the newest producer always wins.
- Outputs change only on rising `clk` or asynchronously on reset.

## Test plan
- **ALU→ALU forward:** EX `addi x5`, `ex_alu_res`=0x10; decode reads rs1=x5. Next cycle `fw_data_1_valid`=1, `fw_data_1`=0x10, `fw_data_2_valid`=0.
- **Load-use:** EX `lw x7`; decode reads rs2=x7.
  - Cycle 0: `stall`=1; next-cycle fw valids are 0.
  - Cycle 1: `mem_load_data`=0xDEADBEEF, `stall`=0.
  - Cycle 2: `fw_data_2`=0xDEADBEEF, valid=1.
- **Priority:** x3 written by WB (0x1), MEM (0x2) and EX (0x3); decode reads x3 → `fw_data_1`=0x3. Repeat with the EX instruction having `ex_reg_write`=0 → 0x2.
- **x0 and unused operands:**
  - EX writes x0 with 0xFF, decode reads rs1=x0 → valid=0.
  - EX writes x4, decode has rs2=x4 but `id_rs2_used`=0 → valid=0.
- **Flush/hazard collision:** load-use hazard with `flush`=1 in the same cycle → `stall`=0 and next-cycle fw outputs all 0.
- **Freeze and reset:**
  - Hold `stall_ext`=1 for 3 cycles with the load-use hazard present → `stall`=1 throughout, fw outputs and slots unchanged.
  - Assert `rst`=0 mid-sequence → `stall`=0 and all fw outputs 0 immediately, no clock edge needed.
